// File: rtl/tmds_period_ctrl.sv
// TMDS period tracker: classifies each incoming character triple as control,
// guard band, video pixel or data island character and reports period framing.
module tmds_period_ctrl #(
    parameter int PREAMBLE_LEN = 8,
    parameter int PKT_LEN      = 32,
    parameter int MAX_PKTS     = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  ch0_raw,
    input  logic [9:0]  ch1_raw,
    input  logic [9:0]  ch2_raw,
    input  logic        ch0_sync_valid,
    input  logic        ch1_sync_valid,
    input  logic        ch2_sync_valid,
    input  logic [1:0]  ch0_sync,
    input  logic [1:0]  ch1_sync,
    input  logic [1:0]  ch2_sync,
    output logic        hsync,
    output logic        vsync,
    output logic        video_de,
    output logic        island_de,
    output logic        pkt_start,
    output logic        line_end,
    output logic        period_err,
    output logic [2:0]  state,
    output logic [11:0] active_width
);

    typedef enum logic [2:0] {
        S_CTRL         = 3'd0,
        S_GB_VID       = 3'd1,
        S_VIDEO        = 3'd2,
        S_GB_ISL_LEAD  = 3'd3,
        S_ISLAND       = 3'd4,
        S_GB_ISL_TRAIL = 3'd5
    } state_t;

    localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int PKT_W = $clog2(MAX_PKTS + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [PKT_W-1:0] PKT_MAX  = PKT_W'(MAX_PKTS);
    localparam logic [PKT_W-1:0] PKT_ONE  = PKT_W'(1);
    localparam logic [3:0]       PRE_THR  = 4'(PREAMBLE_LEN);
    localparam logic [9:0]       GB_A     = 10'b1011001100;
    localparam logic [9:0]       GB_B     = 10'b0100110011;

    state_t           state_r, state_nx;
    logic [3:0]       pre_cnt, prev_ctl;
    logic [11:0]      width_cnt, width_nx, aw_nx;
    logic [IDX_W-1:0] char_idx, idx_nx;
    logic [PKT_W-1:0] pkt_cnt, pkt_nx;
    logic             hsync_nx, vsync_nx, video_de_nx, island_de_nx;
    logic             pkt_start_nx, line_end_nx, err_nx;

    logic       all_ctrl, vid_gb, isl_gb, pre_ok, vid_pre, isl_pre;
    logic [3:0] ctl;

    assign all_ctrl = ch0_sync_valid & ch1_sync_valid & ch2_sync_valid;
    assign ctl      = {ch2_sync, ch1_sync};
    assign vid_gb   = (ch0_raw == GB_A) && (ch1_raw == GB_B) && (ch2_raw == GB_A);
    assign isl_gb   = (ch1_raw == GB_B) && (ch2_raw == GB_B);
    // Preamble qualification looks at the run of control characters that
    // preceded the current (non-control) guard band character.
    assign pre_ok   = (pre_cnt >= PRE_THR);
    assign vid_pre  = (prev_ctl == 4'b0001);
    assign isl_pre  = (prev_ctl == 4'b0101);
    assign state    = state_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt  <= '0;
            prev_ctl <= '0;
        end else if (all_ctrl) begin
            prev_ctl <= ctl;
            if (ctl != prev_ctl)     pre_cnt <= 4'd1;
            else if (pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;
        end else begin
            pre_cnt <= '0;
        end
    end

    always_comb begin
        state_nx     = state_r;
        hsync_nx     = hsync;
        vsync_nx     = vsync;
        video_de_nx  = 1'b0;
        island_de_nx = 1'b0;
        pkt_start_nx = 1'b0;
        line_end_nx  = 1'b0;
        err_nx       = 1'b0;
        aw_nx        = active_width;
        width_nx     = width_cnt;
        idx_nx       = char_idx;
        pkt_nx       = pkt_cnt;
        case (state_r)
            S_CTRL: begin
                if (all_ctrl) begin
                    vsync_nx = ch0_sync[1];
                    hsync_nx = ch0_sync[0];
                end else if (vid_gb && pre_ok && vid_pre) begin
                    state_nx = S_GB_VID;
                end else if (isl_gb && pre_ok && isl_pre) begin
                    state_nx = S_GB_ISL_LEAD;
                end else begin
                    err_nx = 1'b1;
                end
            end
            S_GB_VID: begin
                if (!all_ctrl && vid_gb) begin
                    state_nx = S_VIDEO;
                    width_nx = '0;
                end else begin
                    err_nx = 1'b1;
                end
            end
            S_VIDEO: begin
                if (all_ctrl) begin
                    state_nx    = S_CTRL;
                    aw_nx       = width_cnt;
                    line_end_nx = 1'b1;
                end else begin
                    video_de_nx = 1'b1;
                    if (width_cnt != 12'hFFF) width_nx = width_cnt + 12'd1;
                end
            end
            S_GB_ISL_LEAD: begin
                if (!all_ctrl && isl_gb) begin
                    state_nx = S_ISLAND;
                    idx_nx   = '0;
                    pkt_nx   = '0;
                end else begin
                    err_nx = 1'b1;
                end
            end
            S_ISLAND: begin
                // A guard band is only a trailer when it lands on a packet boundary.
                if (all_ctrl) begin
                    err_nx = 1'b1;
                end else if (char_idx == '0 && pkt_cnt != '0 && isl_gb) begin
                    state_nx = S_GB_ISL_TRAIL;
                end else if (char_idx == '0 && pkt_cnt == PKT_MAX) begin
                    err_nx = 1'b1;
                end else begin
                    island_de_nx = 1'b1;
                    pkt_start_nx = (char_idx == '0);
                    if (char_idx == IDX_LAST) begin
                        idx_nx = '0;
                        pkt_nx = pkt_cnt + PKT_ONE;
                    end else begin
                        idx_nx = char_idx + IDX_ONE;
                    end
                end
            end
            S_GB_ISL_TRAIL: begin
                if (!all_ctrl && isl_gb) state_nx = S_CTRL;
                else                     err_nx   = 1'b1;
            end
            default: state_nx = S_CTRL;
        endcase
        if (err_nx) begin
            state_nx = S_CTRL;
            width_nx = '0;
            idx_nx   = '0;
            pkt_nx   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_CTRL;
            hsync        <= 1'b0;
            vsync        <= 1'b0;
            video_de     <= 1'b0;
            island_de    <= 1'b0;
            pkt_start    <= 1'b0;
            line_end     <= 1'b0;
            period_err   <= 1'b0;
            active_width <= '0;
            width_cnt    <= '0;
            char_idx     <= '0;
            pkt_cnt      <= '0;
        end else begin
            state_r      <= state_nx;
            hsync        <= hsync_nx;
            vsync        <= vsync_nx;
            video_de     <= video_de_nx;
            island_de    <= island_de_nx;
            pkt_start    <= pkt_start_nx;
            line_end     <= line_end_nx;
            period_err   <= err_nx;
            active_width <= aw_nx;
            width_cnt    <= width_nx;
            char_idx     <= idx_nx;
            pkt_cnt      <= pkt_nx;
        end
    end

endmodule
